dot_product_st: RTL and testbench

- Streaming fixed-point dot-product engine for one neuron of the pixel classifier.
- After reset release it consumes PIXEL_N pixel/weight pairs over consecutive clocks: up to PARALLEL*BUS_WIDTH pairs per beat, each beat held BUS_WIDTH cycles.
- Computes sum(pixel*weight) through pipelined multiply and add stages.
- Presents the saturated result on value and holds it until the next reset.

---
 rtl/dot_product_st.sv | 258 +++++++++++++++++++++++++
 tb/tb_dot_product_st.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_st.sv
// dot_product_st: streaming fixed-point dot product for one classifier neuron.
//
// After GlobalReset is released, PIXEL_N pixel/weight pairs are consumed over the
// following cycles. Each beat is held for BUS_WIDTH cycles. In sub-cycle k of a beat,
// lane j takes slot k*PARALLEL+j. Each lane multiplies and accumulates its pairs. The
// lane sums are then reduced by a pipelined adder tree. The result goes through a
// shift-and-saturate output stage and is held on value until the next reset.
//
// Ports:
//   clk         - rising-edge clock
//   GlobalReset - asynchronous active-low reset
//   Pixels      - BUS_WIDTH*PARALLEL unsigned pixel slots, PIXEL_SIZE bits each
//   Weights     - BUS_WIDTH*PARALLEL signed Q2.16 weight slots, WEIGHT_SIZE bits each
//   done        - (only with DOT_PRODUCT_DONE_EN) sticky flag, set with the result
//   value       - saturated signed Q7.18 result
//
// Optional feature macro: DOT_PRODUCT_DONE_EN adds the done output.

module dot_product_st #(
    parameter int unsigned PIXEL_N     = 10,
    parameter int unsigned WEIGHT_SIZE = 19,
    parameter int unsigned PIXEL_SIZE  = 10,
    parameter int unsigned FPM_DELAY   = 6,
    parameter int unsigned FPA_DELAY   = 2,
    parameter int unsigned PARALLEL    = 1,
    parameter int unsigned BUS_WIDTH   = 1,
    parameter int unsigned VAL_SIZE    = 26
) (
    input  logic                                     clk,
    input  logic                                     GlobalReset,
    input  logic [BUS_WIDTH*PARALLEL*PIXEL_SIZE-1:0]  Pixels,
    input  logic [BUS_WIDTH*PARALLEL*WEIGHT_SIZE-1:0] Weights,
`ifdef DOT_PRODUCT_DONE_EN
    output logic                                     done,
`endif
    output logic [VAL_SIZE-1:0]                      value
);

    localparam int unsigned NumSlots = BUS_WIDTH * PARALLEL;
    localparam int unsigned NumBeats = (PIXEL_N + NumSlots - 1) / NumSlots;
    localparam int unsigned NumCyc   = NumBeats * BUS_WIDTH;
    localparam int unsigned CycW     = $clog2(NumCyc + 1);
    localparam int unsigned SubW     = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam int unsigned ProdW    = PIXEL_SIZE + WEIGHT_SIZE + 1;
    localparam int unsigned AccW     = ProdW + $clog2(PIXEL_N) + 1;
    localparam int unsigned Levels   = $clog2(PARALLEL);
    localparam int unsigned NumLeaf  = 1 << Levels;
    localparam int unsigned TreeW    = AccW + Levels;
    localparam int unsigned ShW      = TreeW + 2;
    localparam int unsigned OutRegs  = FPA_DELAY * (Levels + 1);

    // Lane j is fed element cyc*PARALLEL+j. This returns the first cycle at which
    // lane j has no element left.
    function automatic int unsigned lane_cyc(int unsigned lane);
        if (PIXEL_N > lane) begin
            return (PIXEL_N - lane + PARALLEL - 1) / PARALLEL;
        end
        return 0;
    endfunction

    // ---------------------------------------------------------------- stream counters
    logic [CycW-1:0] cyc_q;
    logic [SubW-1:0] sub_q;
    logic            in_last;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            cyc_q <= '0;
            sub_q <= '0;
        end else begin
            // Saturates at NumCyc so the stream, and the last flag, happen exactly once.
            if (cyc_q < CycW'(NumCyc)) begin
                cyc_q <= cyc_q + CycW'(1);
            end
            if (sub_q == SubW'(BUS_WIDTH - 1)) begin
                sub_q <= '0;
            end else begin
                sub_q <= sub_q + SubW'(1);
            end
        end
    end

    assign in_last = (cyc_q == CycW'(NumCyc - 1));

    // ---------------------------------------------------------------- slot selection
    logic [PIXEL_SIZE-1:0]  pix_sel [PARALLEL];
    logic [WEIGHT_SIZE-1:0] wgt_sel [PARALLEL];

    always_comb begin
        for (int j = 0; j < PARALLEL; j++) begin
            pix_sel[j] = '0;
            wgt_sel[j] = '0;
            for (int k = 0; k < BUS_WIDTH; k++) begin
                if (sub_q == SubW'(k)) begin
                    pix_sel[j] = Pixels[(k*PARALLEL+j)*PIXEL_SIZE +: PIXEL_SIZE];
                    wgt_sel[j] = Weights[(k*PARALLEL+j)*WEIGHT_SIZE +: WEIGHT_SIZE];
                end
            end
            // A zeroed pixel makes padding slots and post-stream input contribute 0.
            if (cyc_q >= CycW'(lane_cyc(j))) begin
                pix_sel[j] = '0;
            end
        end
    end

    // ---------------------------------------------------------------- multiplier pipeline
    logic signed [ProdW-1:0] prod_d [PARALLEL];
    logic signed [ProdW-1:0] mul_q  [PARALLEL][FPM_DELAY];
    logic [FPM_DELAY-1:0]    mlast_q;

    always_comb begin
        for (int j = 0; j < PARALLEL; j++) begin
            // The pixel is zero-extended and the weight sign-extended, both to the full
            // product width.
            prod_d[j] = $signed({{(WEIGHT_SIZE + 1){1'b0}}, pix_sel[j]})
                      * $signed({{(PIXEL_SIZE + 1){wgt_sel[j][WEIGHT_SIZE-1]}}, wgt_sel[j]});
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int j = 0; j < PARALLEL; j++) begin
                for (int d = 0; d < FPM_DELAY; d++) begin
                    mul_q[j][d] <= '0;
                end
            end
            mlast_q <= '0;
        end else begin
            for (int j = 0; j < PARALLEL; j++) begin
                mul_q[j][0] <= prod_d[j];
                for (int d = 1; d < FPM_DELAY; d++) begin
                    mul_q[j][d] <= mul_q[j][d-1];
                end
            end
            mlast_q[0] <= in_last;
            for (int d = 1; d < FPM_DELAY; d++) begin
                mlast_q[d] <= mlast_q[d-1];
            end
        end
    end

    // ---------------------------------------------------------------- lane accumulators
    logic signed [AccW-1:0] acc_q [PARALLEL];
    // chain_q carries the single "final sum ready" token. Bit r enables load of
    // reduction/output register r, so these registers stay at 0 until the token passes.
    logic [OutRegs-1:0]     chain_q;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int j = 0; j < PARALLEL; j++) begin
                acc_q[j] <= '0;
            end
            chain_q <= '0;
        end else begin
            for (int j = 0; j < PARALLEL; j++) begin
                acc_q[j] <= acc_q[j] + AccW'(mul_q[j][FPM_DELAY-1]);
            end
            chain_q[0] <= mlast_q[FPM_DELAY-1];
            for (int r = 1; r < OutRegs; r++) begin
                chain_q[r] <= chain_q[r-1];
            end
        end
    end

    // ---------------------------------------------------------------- adder tree
    logic signed [TreeW-1:0] lvl_out [Levels+1][NumLeaf];

    for (genvar n = 0; n < NumLeaf; n++) begin : g_leaf
        if (n < PARALLEL) begin : g_lane
            assign lvl_out[0][n] = TreeW'(acc_q[n]);
        end else begin : g_pad
            assign lvl_out[0][n] = '0;
        end
    end

    for (genvar l = 1; l <= Levels; l++) begin : g_lvl
        for (genvar n = 0; n < NumLeaf; n++) begin : g_node
            if (n < (NumLeaf >> l)) begin : g_add
                logic signed [TreeW-1:0] node_q [FPA_DELAY];

                always_ff @(posedge clk or negedge GlobalReset) begin
                    if (!GlobalReset) begin
                        for (int d = 0; d < FPA_DELAY; d++) begin
                            node_q[d] <= '0;
                        end
                    end else begin
                        if (chain_q[(l-1)*FPA_DELAY]) begin
                            node_q[0] <= lvl_out[l-1][2*n] + lvl_out[l-1][2*n+1];
                        end
                        for (int d = 1; d < FPA_DELAY; d++) begin
                            if (chain_q[(l-1)*FPA_DELAY+d]) begin
                                node_q[d] <= node_q[d-1];
                            end
                        end
                    end
                end

                assign lvl_out[l][n] = node_q[FPA_DELAY-1];
            end else begin : g_unused
                assign lvl_out[l][n] = '0;
            end
        end
    end

    // ---------------------------------------------------------------- output stage
    logic [ShW-1:0]      shifted;
    logic                fits;
    logic [VAL_SIZE-1:0] sat_d;
    logic [VAL_SIZE-1:0] out_q [FPA_DELAY];

    always_comb begin
        // Q.16 to Q.18 conversion, then clamp to the signed VAL_SIZE range.
        shifted = {lvl_out[Levels][0], 2'b00};
        fits    = (&shifted[ShW-1:VAL_SIZE-1]) | ~(|shifted[ShW-1:VAL_SIZE-1]);
        if (fits) begin
            sat_d = shifted[VAL_SIZE-1:0];
        end else if (shifted[ShW-1]) begin
            sat_d = {1'b1, {(VAL_SIZE - 1){1'b0}}};
        end else begin
            sat_d = {1'b0, {(VAL_SIZE - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int d = 0; d < FPA_DELAY; d++) begin
                out_q[d] <= '0;
            end
        end else begin
            if (chain_q[Levels*FPA_DELAY]) begin
                out_q[0] <= sat_d;
            end
            for (int d = 1; d < FPA_DELAY; d++) begin
                if (chain_q[Levels*FPA_DELAY+d]) begin
                    out_q[d] <= out_q[d-1];
                end
            end
        end
    end

    assign value = out_q[FPA_DELAY-1];

`ifdef DOT_PRODUCT_DONE_EN
    logic done_q;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            done_q <= 1'b0;
        end else begin
            // Set on the same edge that loads the final value register.
            done_q <= done_q | chain_q[OutRegs-1];
        end
    end

    assign done = done_q;
`endif

endmodule

// File: tb/tb_dot_product_st.sv
module tb_dot_product_st;

    localparam int unsigned N    = 10;
    localparam int unsigned PS   = 10;
    localparam int unsigned WS   = 19;
    localparam int unsigned VS   = 26;
    localparam int          Lat  = 17;   // defaults: 9 + 6 + 2
    localparam int          Lat2 = 15;   // PARALLEL=2, BUS_WIDTH=2: 5 + 6 + 2*2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              GlobalReset;
    logic [PS-1:0]     Pixels;
    logic [WS-1:0]     Weights;
    logic [VS-1:0]     value;
    logic [4*PS-1:0]   pixels2;
    logic [4*WS-1:0]   weights2;
    logic [VS-1:0]     value2;
`ifdef DOT_PRODUCT_DONE_EN
    logic              done;
    logic              done2;
`endif

    dot_product_st dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .Pixels      (Pixels),
        .Weights     (Weights),
`ifdef DOT_PRODUCT_DONE_EN
        .done        (done),
`endif
        .value       (value)
    );

    dot_product_st #(
        .PARALLEL  (2),
        .BUS_WIDTH (2)
    ) dut2 (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .Pixels      (pixels2),
        .Weights     (weights2),
`ifdef DOT_PRODUCT_DONE_EN
        .done        (done2),
`endif
        .value       (value2)
    );

    typedef struct packed {
        logic [N-1:0][PS-1:0] pix;
        logic [N-1:0][WS-1:0] wgt;
        logic [PS-1:0]        post_pix;
        logic [WS-1:0]        post_wgt;
        logic [VS-1:0]        exp;
    } vec_t;

    localparam int NumVec = 5;
    vec_t          vecs [NumVec];
    logic [VS-1:0] sb [$];
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [VS-1:0] act, input logic [VS-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact integer sum in Q.16, scaled to Q.18, clamped to 26-bit signed.
    function automatic logic [VS-1:0] model(input vec_t v);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'(v.pix[i]) * longint'($signed(v.wgt[i]));
        end
        s = s * 4;
        if (s > longint'(33554431)) return 26'h1FFFFFF;
        if (s < -longint'(33554432)) return 26'h2000000;
        return s[VS-1:0];
    endfunction

    // Called at a negedge (or before the first edge). Returns at a negedge with reset
    // released; the next posedge is input cycle 0.
    task automatic apply_reset();
        GlobalReset = 1'b0;
        sb.delete();
        Pixels   = '0;
        Weights  = '0;
        pixels2  = '0;
        weights2 = '0;
        #1;
        check("reset_value", value, '0);
        check("reset_value2", value2, '0);
`ifdef DOT_PRODUCT_DONE_EN
        check("reset_done", VS'(done), '0);
`endif
        repeat (2) @(negedge clk);
        GlobalReset = 1'b1;
    endtask

    task automatic run_vec(input int idx, input int ncyc);
        vec_t          v;
        logic [VS-1:0] held;
        v    = vecs[idx];
        held = '0;
        sb.push_back(v.exp);
        for (int n = 0; n < ncyc; n++) begin
            if (n < N) begin
                Pixels  = v.pix[n];
                Weights = v.wgt[n];
            end else begin
                Pixels  = v.post_pix;
                Weights = v.post_wgt;
            end
            @(posedge clk);
            #1;
            if (n < Lat) begin
                check($sformatf("v%0d_pre_c%0d", idx, n), value, '0);
            end else if (n == Lat) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL v%0d_sb_empty: got no entry, expected one", idx);
                end else begin
                    held = sb.pop_front();
                end
                check($sformatf("v%0d_result_c%0d", idx, n), value, held);
            end else begin
                check($sformatf("v%0d_hold_c%0d", idx, n), value, held);
            end
`ifdef DOT_PRODUCT_DONE_EN
            check($sformatf("v%0d_done_c%0d", idx, n), VS'(done), VS'(n >= Lat));
`endif
            @(negedge clk);
        end
    endtask

    // Two lanes, two sub-cycles: 4 slots per beat, beat held 2 cycles, C = 6.
    task automatic run_par(input int ncyc);
        logic [VS-1:0] held;
        int            e;
        held = '0;
        sb.push_back(26'h1680000);
        for (int n = 0; n < ncyc; n++) begin
            for (int s = 0; s < 4; s++) begin
                e = 4 * (n / 2) + s;
                if (n < 6 && e < N) begin
                    pixels2[s*PS +: PS] = PS'(e);
                end else begin
                    pixels2[s*PS +: PS] = 10'h3FF;
                end
                weights2[s*WS +: WS] = 19'h20000;
            end
            @(posedge clk);
            #1;
            if (n < Lat2) begin
                check($sformatf("par_pre_c%0d", n), value2, '0);
            end else if (n == Lat2) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL par_sb_empty: got no entry, expected one");
                end else begin
                    held = sb.pop_front();
                end
                check($sformatf("par_result_c%0d", n), value2, held);
            end else begin
                check($sformatf("par_hold_c%0d", n), value2, held);
            end
`ifdef DOT_PRODUCT_DONE_EN
            check($sformatf("par_done_c%0d", n), VS'(done2), VS'(n >= Lat2));
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            vecs[0].pix[i] = PS'(i);
            vecs[0].wgt[i] = 19'h20000;
            vecs[1].pix[i] = 10'h3FF;
            vecs[1].wgt[i] = 19'h70000;
            vecs[2].pix[i] = 10'h3FF;
            vecs[2].wgt[i] = 19'h3FFFF;
            vecs[3].pix[i] = PS'(i + 1);
            vecs[3].wgt[i] = (i % 2 == 0) ? 19'h10000 : 19'h7C000;
            vecs[4].pix[i] = PS'($urandom_range(0, 63));
            vecs[4].wgt[i] = WS'($urandom_range(0, 524287));
        end
        for (int i = 0; i < NumVec; i++) begin
            vecs[i].post_pix = '0;
            vecs[i].post_wgt = '0;
        end
        // Garbage after the stream must be ignored.
        vecs[3].post_pix = 10'h3FF;
        vecs[3].post_wgt = 19'h3FFFF;
        vecs[0].exp = 26'h1680000;
        vecs[1].exp = 26'h2000000;
        vecs[2].exp = 26'h1FFFFFF;
        vecs[3].exp = model(vecs[3]);
        vecs[4].exp = model(vecs[4]);

        GlobalReset = 1'b1;
        Pixels      = '0;
        Weights     = '0;
        pixels2     = '0;
        weights2    = '0;
        #2;
        apply_reset();

        for (int i = 0; i < NumVec; i++) begin
            run_vec(i, (i == 0) ? 118 : 24);
            apply_reset();
        end

        // Reset pulse at input cycle 5, then replay.
        run_vec(0, 5);
        apply_reset();
        run_vec(0, 24);
        apply_reset();

        // Reset while products are still in flight; a different stream follows.
        run_vec(0, 12);
        apply_reset();
        run_vec(1, 24);
        apply_reset();

        run_par(24);
        apply_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
